// File: rtl/tile_sequencer.sv
// Tiled-GEMM sequencer: walks n (outer), k, m (inner) and issues weight-load, compute and
// drain requests, prefetching the next weight tile into a free buffer while compute runs.
module tile_sequencer #(
  parameter int SYS_ARR_ROWS = 8,
  parameter int SYS_ARR_COLS = 8,
  parameter int MAX_MAT_WH   = 128,
  parameter int NUM_WBUF     = 2,
  localparam int TW = $clog2(MAX_MAT_WH / SYS_ARR_ROWS),
  localparam int BW = (NUM_WBUF > 1) ? $clog2(NUM_WBUF) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [TW:0]   m_tiles,
  input  logic [TW:0]   k_tiles,
  input  logic [TW:0]   n_tiles,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          wl_req,
  output logic [TW-1:0] wl_k,
  output logic [TW-1:0] wl_n,
  output logic [BW-1:0] wl_buf,
  input  logic          wl_ack,
  output logic          mm_req,
  output logic [TW-1:0] mm_m,
  output logic [TW-1:0] mm_k,
  output logic [BW-1:0] mm_buf,
  output logic          mm_clear,
  input  logic          mm_ack,
  output logic          dr_req,
  output logic [TW-1:0] dr_m,
  output logic [TW-1:0] dr_n,
  input  logic          dr_ack
);

  localparam int NB     = 1 << BW;
  localparam int MAXT_R = MAX_MAT_WH / SYS_ARR_ROWS;
  localparam int MAXT_C = MAX_MAT_WH / SYS_ARR_COLS;
  localparam int MAXT   = (MAXT_R < MAXT_C) ? MAXT_R : MAXT_C;
  localparam logic [TW:0] MAXT_V = (TW+1)'(MAXT);

  typedef enum logic [0:0] {L_IDLE, L_REQ} lstate_t;
  typedef enum logic [2:0] {C_IDLE, C_WAIT, C_MM, C_DRAIN, C_DONE} cstate_t;

  lstate_t       lst_q;
  cstate_t       cst_q;
  logic          busy_q, done_q, err_q;
  logic [TW:0]   m_cnt_q, k_cnt_q, n_cnt_q;
  logic [TW-1:0] lk_q, ln_q;
  logic          lmore_q;
  logic [BW-1:0] wr_ptr_q, rd_ptr_q;
  logic [NB-1:0] valid_q;
  logic [TW-1:0] cm_q, ck_q, cn_q;
  logic          wl_req_q, mm_req_q, dr_req_q, mm_clear_q;
  logic [TW-1:0] wl_k_q, wl_n_q, mm_m_q, mm_k_q, dr_m_q, dr_n_q;
  logic [BW-1:0] wl_buf_q, mm_buf_q;

  logic          wl_fire, mm_fire, dims_bad;
  logic [NB-1:0] set_mask, clr_mask, valid_d;

  function automatic logic is_last(input logic [TW-1:0] idx, input logic [TW:0] cnt);
    return ({1'b0, idx} + (TW+1)'(1)) == cnt;
  endfunction

  function automatic logic [BW-1:0] next_buf(input logic [BW-1:0] p);
    return (p == BW'(NUM_WBUF - 1)) ? '0 : p + BW'(1);
  endfunction

  // Loader sets and compute clears can hit different buffers in the same cycle.
  always_comb begin
    wl_fire  = wl_req_q & wl_ack;
    mm_fire  = mm_req_q & mm_ack;
    set_mask = wl_fire ? (NB'(1) << wr_ptr_q) : '0;
    clr_mask = (mm_fire && is_last(cm_q, m_cnt_q)) ? (NB'(1) << rd_ptr_q) : '0;
    valid_d  = (valid_q | set_mask) & ~clr_mask;
    dims_bad = (m_tiles == '0) || (m_tiles > MAXT_V) ||
               (k_tiles == '0) || (k_tiles > MAXT_V) ||
               (n_tiles == '0) || (n_tiles > MAXT_V);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lst_q      <= L_IDLE;
      cst_q      <= C_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      m_cnt_q    <= '0;
      k_cnt_q    <= '0;
      n_cnt_q    <= '0;
      lk_q       <= '0;
      ln_q       <= '0;
      lmore_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      valid_q    <= '0;
      cm_q       <= '0;
      ck_q       <= '0;
      cn_q       <= '0;
      wl_req_q   <= 1'b0;
      mm_req_q   <= 1'b0;
      dr_req_q   <= 1'b0;
      mm_clear_q <= 1'b0;
      wl_k_q     <= '0;
      wl_n_q     <= '0;
      wl_buf_q   <= '0;
      mm_m_q     <= '0;
      mm_k_q     <= '0;
      mm_buf_q   <= '0;
      dr_m_q     <= '0;
      dr_n_q     <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= 1'b0;

      // Loader: one outstanding weight load, only into an empty buffer.
      case (lst_q)
        L_IDLE: begin
          if (lmore_q && !valid_q[wr_ptr_q]) begin
            wl_req_q <= 1'b1;
            wl_k_q   <= lk_q;
            wl_n_q   <= ln_q;
            wl_buf_q <= wr_ptr_q;
            lst_q    <= L_REQ;
          end
        end
        L_REQ: begin
          if (wl_ack) begin
            wl_req_q <= 1'b0;
            wr_ptr_q <= next_buf(wr_ptr_q);
            lst_q    <= L_IDLE;
            if (is_last(lk_q, k_cnt_q)) begin
              lk_q <= '0;
              if (is_last(ln_q, n_cnt_q)) lmore_q <= 1'b0;
              else                        ln_q    <= ln_q + TW'(1);
            end else begin
              lk_q <= lk_q + TW'(1);
            end
          end
        end
        default: lst_q <= L_IDLE;
      endcase

      case (cst_q)
        C_IDLE: begin
          if (start) begin
            if (dims_bad) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
              cst_q  <= C_DONE;
            end else begin
              err_q    <= 1'b0;
              busy_q   <= 1'b1;
              m_cnt_q  <= m_tiles;
              k_cnt_q  <= k_tiles;
              n_cnt_q  <= n_tiles;
              cm_q     <= '0;
              ck_q     <= '0;
              cn_q     <= '0;
              rd_ptr_q <= '0;
              wr_ptr_q <= '0;
              valid_q  <= '0;
              lk_q     <= '0;
              ln_q     <= '0;
              lmore_q  <= 1'b1;
              lst_q    <= L_IDLE;
              cst_q    <= C_WAIT;
            end
          end
        end
        C_WAIT: begin
          if (valid_q[rd_ptr_q]) cst_q <= C_MM;
        end
        C_MM: begin
          if (!mm_req_q) begin
            mm_req_q   <= 1'b1;
            mm_m_q     <= cm_q;
            mm_k_q     <= ck_q;
            mm_buf_q   <= rd_ptr_q;
            mm_clear_q <= (ck_q == '0);
          end else if (mm_ack) begin
            mm_req_q   <= 1'b0;
            mm_clear_q <= 1'b0;
            if (is_last(cm_q, m_cnt_q)) begin
              cm_q     <= '0;
              rd_ptr_q <= next_buf(rd_ptr_q);
              if (is_last(ck_q, k_cnt_q)) begin
                cst_q <= C_DRAIN;
              end else begin
                ck_q  <= ck_q + TW'(1);
                cst_q <= C_WAIT;
              end
            end else begin
              cm_q <= cm_q + TW'(1);
            end
          end
        end
        C_DRAIN: begin
          if (!dr_req_q) begin
            dr_req_q <= 1'b1;
            dr_m_q   <= cm_q;
            dr_n_q   <= cn_q;
          end else if (dr_ack) begin
            dr_req_q <= 1'b0;
            if (is_last(cm_q, m_cnt_q)) begin
              cm_q <= '0;
              if (is_last(cn_q, n_cnt_q)) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
                cst_q  <= C_DONE;
              end else begin
                cn_q  <= cn_q + TW'(1);
                ck_q  <= '0;
                cst_q <= C_WAIT;
              end
            end else begin
              cm_q <= cm_q + TW'(1);
            end
          end
        end
        C_DONE:  cst_q <= C_IDLE;
        default: cst_q <= C_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign wl_req   = wl_req_q;
  assign wl_k     = wl_k_q;
  assign wl_n     = wl_n_q;
  assign wl_buf   = wl_buf_q;
  assign mm_req   = mm_req_q;
  assign mm_m     = mm_m_q;
  assign mm_k     = mm_k_q;
  assign mm_buf   = mm_buf_q;
  assign mm_clear = mm_clear_q;
  assign dr_req   = dr_req_q;
  assign dr_m     = dr_m_q;
  assign dr_n     = dr_n_q;

endmodule

// File: doc/tile_sequencer.md
Name: tile_sequencer

Overview:
- Tiled-GEMM sequencer for the systolic accelerator. Computes C[M×N] = A[M×K]·B[K×N] for matrices up to MAX_MAT_WH, using SYS_ARR_ROWS×SYS_ARR_COLS tiles.
- Issues weight-load, compute and drain requests to the existing fifo/rd_control/accumTable/outputMem controllers.
- Request/ack handshakes are independent per channel.
- Weight buffers are multi-buffered, so loading tile k+1 overlaps compute on tile k. Single-tile master control cannot do this.

Parameters:
- SYS_ARR_ROWS, 8, array rows (m-tile height).
- SYS_ARR_COLS, 8, array columns (k/n tile width).
- MAX_MAT_WH, 128, max matrix dimension.
- NUM_WBUF, 2, weight buffers (1 or 2); 1 gives serial load/compute.
- Derived: TW = clog2(MAX_MAT_WH/SYS_ARR_ROWS); BW = max(1, clog2(NUM_WBUF)).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous reset, active-low (0 = reset).
- start  in  1  one-cycle launch pulse; ignored while busy.
- m_tiles, k_tiles, n_tiles  in  TW+1 each  tile counts; legal range 1..MAX_MAT_WH/SYS_ARR_ROWS; sampled on start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at completion.
- err  out  1  sticky; set on illegal dims; cleared by the next accepted start.
- wl_req  out  1  weight-load request.
- wl_k, wl_n  out  TW each  tile indices for the weight load.
- wl_buf  out  BW  target weight buffer.
- wl_ack  in  1  load-complete pulse.
- mm_req  out  1  compute request.
- mm_m, mm_k  out  TW each  tile indices for the compute.
- mm_buf  out  BW  weight buffer to use.
- mm_clear  out  1  accumulator clear; high when mm_k==0.
- mm_ack  in  1  compute-complete pulse.
- dr_req  out  1  drain request (relu/outputMem write of one submatrix).
- dr_m, dr_n  out  TW each  submatrix to drain.
- dr_ack  in  1  drain-complete pulse.

Behaviour:
- Reset values: busy, done, err, all *_req and mm_clear are 0; all index and buffer outputs are 0; all buffers invalid; pointers are 0.
- Handshake (all three channels):
  - req rises together with stable indices and is held until ack is sampled high.
  - req falls on the cycle after ack; indices stay unchanged while req is high.
  - An ack arriving while req is low is ignored.
  - A new req may rise on the cycle after the previous one falls (no back-to-back in the ack cycle).
- Loop order is n outer, k middle, m inner. Each weight tile is loaded once and reused across all m.
- Start handling: dims are sampled on accepted start.
  - If any dim is 0 or exceeds MAX_MAT_WH/SYS_ARR_ROWS: err=1, done pulses the next cycle, busy never asserts.
- Loader engine (L_IDLE, L_REQ):
  - Walks (k,n) in order.
  - Enters L_REQ when another load remains and buffer wr_ptr is invalid.
  - On wl_ack: set valid[wr_ptr], advance wr_ptr modulo NUM_WBUF, advance (k,n).
  - Returns to L_IDLE after the last load (k_tiles·n_tiles loads total).
- Compute engine (C_IDLE, C_WAIT, C_MM, C_DRAIN, C_DONE):
  - C_WAIT → C_MM when valid[rd_ptr] is set.
  - C_MM issues mm_req for m = 0..m_tiles-1 with mm_buf=rd_ptr and the current k.
  - After the ack for the last m: clear valid[rd_ptr] and advance rd_ptr.
    - If k < k_tiles-1: go to C_WAIT with k+1.
    - Otherwise go to C_DRAIN.
  - C_DRAIN issues dr_req for m = 0..m_tiles-1 at the current n. The loader keeps prefetching during drain.
  - After the last dr_ack: if n < n_tiles-1, go to C_WAIT with n+1 and k=0; otherwise go to C_DONE.
  - C_DONE: done=1 for one cycle, busy=0, return to C_IDLE.
- Simultaneous events:
  - A loader set and a compute clear on different buffers in the same cycle both take effect.
  - The same buffer cannot be set and cleared in one cycle (the loader only targets invalid buffers).
- NUM_WBUF=1: the loader stalls until compute frees the buffer, so load and compute never overlap.
- Totals per job: k·n loads, m·k·n computes, m·n drains. All counters wrap only at their tile-count limits.
- Async reset mid-operation: all outputs return to reset values immediately. Outstanding acks after reset are ignored.

Test Plan:
- Dims 1/1/1 → wl(0,0,buf0), then mm(0,0,buf0,clear=1), then dr(0,0), then done pulse. busy is high for the whole sequence.
- m=2,k=3,n=2 with 1-cycle acks → 6 wl, 12 mm, 4 dr in loop order n,k,m. mm_clear is high only on k=0. mm_buf alternates 0,1,0,1,0,1.
- NUM_WBUF=2 with mm_ack delayed 20 cycles → wl_req for (k=1,n=0) is high while mm_req for (k=0) is outstanding. NUM_WBUF=1 with the same stimulus → no overlap.
- Start with k_tiles=0 → err=1, done pulse on the next cycle, no reqs. A subsequent legal start clears err.
- Reset pulled low while mm_req is high mid-job → all reqs drop asynchronously. A stray mm_ack after release is ignored. A fresh start runs cleanly.
- Start pulsed while busy → ignored; tile counts and sequence are unchanged.
